// File: rtl/cim_unit_multicore.sv
// Multicore CIM unit: one active compute core plus shadow cores that are reloaded
// row by row over a valid/ready channel and swapped in as the active core on request.

// Single CIM core: ROWS x WROW_W weight array with a write/readback port, and a
// 3-activation 4b MAC per 18b PSUM lane against the row picked by the slide pointer.
module cim_core #(
    parameter int ROWS   = 64,
    parameter int WROW_W = 2304,
    parameter int ACT_W  = 256,
    parameter int PSUM_W = 1152,
    parameter int AW     = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cim_en_i,
    input  logic              slide_en_i,
    input  logic [ACT_W-1:0]  act1_i,
    input  logic [ACT_W-1:0]  act2_i,
    input  logic [ACT_W-1:0]  act3_i,
    input  logic              stdw_i,
    input  logic              stdr_i,
    input  logic [AW-1:0]     std_a_i,
    input  logic [WROW_W-1:0] weight_i,
    output logic [WROW_W-1:0] weight_o,
    output logic [PSUM_W-1:0] psum_o
);
    localparam int LANES = PSUM_W / 18;

    logic [WROW_W-1:0] mem_q [ROWS];
    logic [AW-1:0]     ptr_q;
    logic [WROW_W-1:0] wrow;

    // Weight storage is deliberately not reset: a reset only abandons a partial load.
    always_ff @(posedge clk) begin
        if (stdw_i) mem_q[std_a_i] <= weight_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (slide_en_i) begin
            ptr_q <= (ptr_q == AW'(ROWS-1)) ? '0 : ptr_q + AW'(1);
        end
    end

    function automatic logic [17:0] mul4(input logic [3:0] a, input logic [3:0] b);
        return {14'd0, a} * {14'd0, b};
    endfunction

    assign weight_o = stdr_i ? mem_q[std_a_i] : '0;
    assign wrow     = mem_q[ptr_q];

    always_comb begin
        psum_o = '0;
        if (cim_en_i) begin
            for (int j = 0; j < LANES; j++) begin
                psum_o[18*j +: 18] = mul4(act1_i[4*j +: 4], wrow[12*j +: 4])
                                   + mul4(act2_i[4*j +: 4], wrow[12*j+4 +: 4])
                                   + mul4(act3_i[4*j +: 4], wrow[12*j+8 +: 4]);
            end
        end
    end
endmodule

module cim_unit_multicore #(
    parameter int NUM_CORES = 2,
    parameter int ROWS      = 64,
    parameter int WROW_W    = 2304,
    parameter int ACT_W     = 256,
    parameter int PSUM_W    = 1152,
    localparam int CW       = $clog2(NUM_CORES),
    localparam int AW       = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cim_en,
    input  logic              slide_en,
    input  logic [ACT_W-1:0]  act_in1,
    input  logic [ACT_W-1:0]  act_in2,
    input  logic [ACT_W-1:0]  act_in3,
    // Weight load: a beat transfers on any rising edge where wl_valid && wl_ready.
    input  logic              wl_valid,
    output logic              wl_ready,
    input  logic [WROW_W-1:0] wl_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              loaded,
    output logic [CW-1:0]     active_core,
    input  logic              rd_req,
    input  logic [CW-1:0]     rd_core,
    input  logic [AW-1:0]     rd_row,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [WROW_W-1:0] rd_data,
    output logic [PSUM_W-1:0] psum,
    output logic              psum_valid,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_LOADED = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     active_q, active_d, tgt;
    logic [AW-1:0]     row_cnt_q, row_cnt_d;
    logic              beat_acc, swap_go, rd_in_range, rd_ok;
    logic              swap_ack_q, rd_valid_q, rd_err_q, psum_valid_q;
    logic [WROW_W-1:0] rd_data_q, rd_sel;
    logic [PSUM_W-1:0] psum_q, psum_sel;
    logic [NUM_CORES-1:0] core_stdw, core_stdr;
    logic [WROW_W-1:0] core_rdata [NUM_CORES];
    logic [PSUM_W-1:0] core_psum  [NUM_CORES];

    assign tgt      = (active_q == CW'(NUM_CORES-1)) ? '0 : active_q + CW'(1);
    assign wl_ready = (state_q != S_LOADED);
    assign beat_acc = wl_valid & wl_ready;
    assign swap_go  = (state_q == S_LOADED) & swap_req & ~cim_en;

    always_comb begin
        rd_in_range = 1'b0;
        rd_sel      = '0;
        psum_sel    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rd_core == CW'(i)) begin
                rd_in_range = 1'b1;
                rd_sel      = core_rdata[i];
            end
            if (active_q == CW'(i)) psum_sel = core_psum[i];
        end
    end

    // A beat in the same cycle owns the shadow core's address port, so readback loses.
    assign rd_ok = rd_req & ~beat_acc & (state_q != S_LOAD) & (rd_core != active_q) & rd_in_range;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic [AW-1:0] core_addr;
        assign core_stdw[g] = beat_acc & (tgt == CW'(g));
        assign core_stdr[g] = rd_ok & (rd_core == CW'(g));
        assign core_addr    = core_stdw[g] ? row_cnt_q : rd_row;

        cim_core #(
            .ROWS(ROWS), .WROW_W(WROW_W), .ACT_W(ACT_W), .PSUM_W(PSUM_W), .AW(AW)
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .cim_en_i  (cim_en),
            .slide_en_i(slide_en),
            .act1_i    (act_in1),
            .act2_i    (act_in2),
            .act3_i    (act_in3),
            .stdw_i    (core_stdw[g]),
            .stdr_i    (core_stdr[g]),
            .std_a_i   (core_addr),
            .weight_i  (wl_data),
            .weight_o  (core_rdata[g]),
            .psum_o    (core_psum[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        active_d  = active_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (beat_acc) begin
                    if (row_cnt_q == AW'(ROWS-1)) begin
                        row_cnt_d = '0;
                        state_d   = S_LOADED;
                    end else begin
                        row_cnt_d = row_cnt_q + AW'(1);
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOADED: begin
                if (swap_go) begin
                    active_d = tgt;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            active_q     <= '0;
            row_cnt_q    <= '0;
            swap_ack_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            row_cnt_q    <= row_cnt_d;
            swap_ack_q   <= swap_go;
            rd_valid_q   <= rd_ok;
            rd_err_q     <= rd_req & ~rd_ok;
            if (rd_ok) rd_data_q <= rd_sel;
            psum_q       <= psum_sel;
            psum_valid_q <= cim_en;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign loaded      = (state_q == S_LOADED);
    assign active_core = active_q;
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
    assign psum        = psum_q;
    assign psum_valid  = psum_valid_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_cim_unit_multicore.sv
// Drives a 2-core and a 4-core unit with identical stimulus and checks every output
// each cycle against a row-level reference model of each unit.
module tb_cim_unit_multicore;
    localparam int ROWS   = 64;
    localparam int WROW_W = 2304;
    localparam int ACT_W  = 256;
    localparam int PSUM_W = 1152;
    localparam int LANES  = PSUM_W / 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cim_en, slide_en, wl_valid, swap_req, rd_req;
    logic [ACT_W-1:0]  act1, act2, act3;
    logic [WROW_W-1:0] wl_data;
    logic [1:0]        rd_core;
    logic [5:0]        rd_row;

    logic              d2_wl_ready, d2_swap_ack, d2_loaded, d2_rd_valid, d2_rd_err, d2_psum_valid;
    logic [0:0]        d2_active;
    logic [WROW_W-1:0] d2_rd_data;
    logic [PSUM_W-1:0] d2_psum;
    logic [1:0]        d2_dbg;
    logic              d4_wl_ready, d4_swap_ack, d4_loaded, d4_rd_valid, d4_rd_err, d4_psum_valid;
    logic [1:0]        d4_active;
    logic [WROW_W-1:0] d4_rd_data;
    logic [PSUM_W-1:0] d4_psum;
    logic [1:0]        d4_dbg;

    always #5 clk = ~clk;

    cim_unit_multicore #(.NUM_CORES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cim_en(cim_en), .slide_en(slide_en),
        .act_in1(act1), .act_in2(act2), .act_in3(act3),
        .wl_valid(wl_valid), .wl_ready(d2_wl_ready), .wl_data(wl_data),
        .swap_req(swap_req), .swap_ack(d2_swap_ack), .loaded(d2_loaded), .active_core(d2_active),
        .rd_req(rd_req), .rd_core(rd_core[0:0]), .rd_row(rd_row),
        .rd_valid(d2_rd_valid), .rd_err(d2_rd_err), .rd_data(d2_rd_data),
        .psum(d2_psum), .psum_valid(d2_psum_valid), .dbg_state(d2_dbg)
    );

    cim_unit_multicore #(.NUM_CORES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cim_en(cim_en), .slide_en(slide_en),
        .act_in1(act1), .act_in2(act2), .act_in3(act3),
        .wl_valid(wl_valid), .wl_ready(d4_wl_ready), .wl_data(wl_data),
        .swap_req(swap_req), .swap_ack(d4_swap_ack), .loaded(d4_loaded), .active_core(d4_active),
        .rd_req(rd_req), .rd_core(rd_core), .rd_row(rd_row),
        .rd_valid(d4_rd_valid), .rd_err(d4_rd_err), .rd_data(d4_rd_data),
        .psum(d4_psum), .psum_valid(d4_psum_valid), .dbg_state(d4_dbg)
    );

    // Reference model, index 0 = 2-core unit, index 1 = 4-core unit.
    logic [WROW_W-1:0] m_mem   [2][4][ROWS];
    bit                m_known [2][4][ROWS];
    int                m_active[2], m_rowcnt[2], m_ptr[2];
    bit                m_loaded[2], m_loading[2], m_swap_ack[2], m_rd_valid[2], m_rd_err[2];
    bit                m_psum_valid[2], m_rd_known[2], m_psum_known[2];
    logic [WROW_W-1:0] m_rd_data[2];
    logic [PSUM_W-1:0] m_psum[2];
    int                n_assert = 0;
    int                n_fail = 0;

    function automatic int ncores(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [WROW_W-1:0] rand_row();
        logic [WROW_W-1:0] r;
        for (int i = 0; i < WROW_W/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_acts();
        for (int i = 0; i < ACT_W/32; i++) begin
            act1[32*i +: 32] = $urandom;
            act2[32*i +: 32] = $urandom;
            act3[32*i +: 32] = $urandom;
        end
    endtask

    // Each PSUM lane j: sum over the three activations of act nibble j times weight nibble 3j+k.
    function automatic logic [PSUM_W-1:0] model_psum(input logic [WROW_W-1:0] w);
        logic [PSUM_W-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            s = int'(act1[4*j +: 4]) * int'(w[12*j +: 4])
              + int'(act2[4*j +: 4]) * int'(w[12*j+4 +: 4])
              + int'(act3[4*j +: 4]) * int'(w[12*j+8 +: 4]);
            r[18*j +: 18] = 18'(s);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0;      m_rowcnt[d] = 0;     m_ptr[d] = 0;
            m_loaded[d] = 0;      m_loading[d] = 0;    m_swap_ack[d] = 0;
            m_rd_valid[d] = 0;    m_rd_err[d] = 0;     m_rd_data[d] = '0;
            m_psum[d] = '0;       m_psum_valid[d] = 0;
            m_rd_known[d] = 1;    m_psum_known[d] = 1;
        end
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            int n, rc, tgt;
            bit acc, rd_ok;
            n     = ncores(d);
            rc    = int'(rd_core) % n;
            tgt   = (m_active[d] + 1) % n;
            acc   = wl_valid && !m_loaded[d];
            rd_ok = rd_req && !acc && !m_loading[d] && (rc != m_active[d]);
            m_psum_valid[d] = cim_en;
            m_psum_known[d] = !cim_en || m_known[d][m_active[d]][m_ptr[d]];
            m_psum[d]       = cim_en ? model_psum(m_mem[d][m_active[d]][m_ptr[d]]) : '0;
            m_rd_valid[d]   = rd_ok;
            m_rd_err[d]     = rd_req && !rd_ok;
            if (rd_ok) begin
                m_rd_data[d]  = m_mem[d][rc][rd_row];
                m_rd_known[d] = m_known[d][rc][rd_row];
            end
            m_swap_ack[d] = m_loaded[d] && swap_req && !cim_en;
            if (acc) begin
                m_mem[d][tgt][m_rowcnt[d]]   = wl_data;
                m_known[d][tgt][m_rowcnt[d]] = 1;
                m_loaded[d]  = (m_rowcnt[d] == ROWS-1);
                m_loading[d] = (m_rowcnt[d] != ROWS-1);
                m_rowcnt[d]  = (m_rowcnt[d] + 1) % ROWS;
            end
            if (m_swap_ack[d]) begin
                m_active[d] = tgt;
                m_loaded[d] = 0;
            end
            if (slide_en) m_ptr[d] = (m_ptr[d] + 1) % ROWS;
        end
    endtask

    task automatic chk(input string tag, input string name, input int d,
                       input logic [WROW_W-1:0] obs, input logic [WROW_W-1:0] exp);
        int w;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            w = 0;
            for (int i = WROW_W/32-1; i >= 0; i--) if (obs[32*i +: 32] !== exp[32*i +: 32]) w = i;
            $error("FAIL %s.%s (%0d-core): word%0d observed %h expected %h",
                   tag, name, ncores(d), w, obs[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    task automatic check_dut(input string tag, input int d, input logic rdy, input logic ld,
                             input int act, input logic ack, input logic rv, input logic re,
                             input logic [WROW_W-1:0] rdat, input logic [PSUM_W-1:0] ps,
                             input logic pv, input logic [1:0] st);
        int exp_st;
        exp_st = m_loaded[d] ? 2 : (m_loading[d] ? 1 : 0);
        chk(tag, "wl_ready",    d, WROW_W'(rdy), WROW_W'(!m_loaded[d]));
        chk(tag, "loaded",      d, WROW_W'(ld),  WROW_W'(m_loaded[d]));
        chk(tag, "active_core", d, WROW_W'(act), WROW_W'(m_active[d]));
        chk(tag, "swap_ack",    d, WROW_W'(ack), WROW_W'(m_swap_ack[d]));
        chk(tag, "rd_valid",    d, WROW_W'(rv),  WROW_W'(m_rd_valid[d]));
        chk(tag, "rd_err",      d, WROW_W'(re),  WROW_W'(m_rd_err[d]));
        chk(tag, "psum_valid",  d, WROW_W'(pv),  WROW_W'(m_psum_valid[d]));
        chk(tag, "state",       d, WROW_W'(st),  WROW_W'(exp_st));
        if (m_rd_known[d])   chk(tag, "rd_data", d, rdat, m_rd_data[d]);
        if (m_psum_known[d]) chk(tag, "psum",    d, WROW_W'(ps), WROW_W'(m_psum[d]));
    endtask

    task automatic check_all(input string tag);
        check_dut(tag, 0, d2_wl_ready, d2_loaded, int'(d2_active), d2_swap_ack, d2_rd_valid,
                  d2_rd_err, d2_rd_data, d2_psum, d2_psum_valid, d2_dbg);
        check_dut(tag, 1, d4_wl_ready, d4_loaded, int'(d4_active), d4_swap_ack, d4_rd_valid,
                  d4_rd_err, d4_rd_data, d4_psum, d4_psum_valid, d4_dbg);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic set_idle();
        wl_valid = 0; swap_req = 0; rd_req = 0; cim_en = 0; slide_en = 0;
        rd_core = '0; rd_row = '0;
    endtask

    task automatic rand_side();
        cim_en   = ($urandom_range(0, 1) == 1);
        slide_en = ($urandom_range(0, 1) == 1);
        rd_req   = ($urandom_range(0, 3) == 0);
        rd_core  = 2'($urandom_range(0, 3));
        rd_row   = 6'($urandom_range(0, ROWS-1));
        rand_acts();
    endtask

    task automatic load_set(input string tag, input int nrows, input bit index_data);
        for (int k = 0; k < nrows; k++) begin
            rand_side();
            wl_valid = 1;
            wl_data  = index_data ? WROW_W'(k) : rand_row();
            step(tag);
        end
        wl_valid = 0;
    endtask

    task automatic do_swap(input string tag);
        rd_req = 0; wl_valid = 0; swap_req = 1;
        for (int t = 0; t < 3; t++) begin
            cim_en = (t < 2);
            step(tag);
        end
        swap_req = 0;
        cim_en = 0;
        step(tag);
    endtask

    task automatic read_all(input string tag, input logic [1:0] core);
        wl_valid = 0; cim_en = 0; swap_req = 0;
        for (int r = 0; r < ROWS; r++) begin
            rd_req = 1; rd_core = core; rd_row = 6'(r);
            step(tag);
        end
        rd_req = 0;
        step(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        act1 = '0; act2 = '0; act3 = '0; wl_data = '0;
        model_reset();
        for (int i = 0; i < 3; i++) step("reset");
        rst_n = 1;
        step("idle");

        // First load into core1 with row-index data, then hold valid while full.
        load_set("load1", ROWS, 1'b1);
        wl_valid = 1; rd_req = 0; cim_en = 0;
        for (int i = 0; i < 3; i++) step("load1_full");
        read_all("load1_rb", 2'd1);

        // Swap stalled by compute for five cycles, then performed.
        swap_req = 1; cim_en = 1; wl_valid = 0;
        for (int i = 0; i < 5; i++) step("swap_stall");
        cim_en = 0;
        step("swap_go");
        swap_req = 0;
        step("swap_done");
        swap_req = 1;
        for (int i = 0; i < 2; i++) step("swap_idle_ignored");
        swap_req = 0;

        // Alternating valid: 64 accepted beats over 128 cycles.
        for (int i = 0; i < 2*ROWS; i++) begin
            rand_side();
            rd_req   = 0;
            wl_valid = (i % 2 == 0);
            wl_data  = rand_row();
            step("toggle");
        end
        wl_valid = 0;
        do_swap("swap2");

        // Readback in IDLE: core1 accepted, the active core rejected.
        rd_req = 1; rd_core = 2'd1; rd_row = 6'd5;
        step("rd_ok");
        rd_core = 2'd2;
        step("rd_active");
        rd_req = 0;
        step("rd_quiet");

        // Three further load+swap rounds walk the active index around the ring.
        for (int n = 0; n < 3; n++) begin
            load_set("ring_load", ROWS, 1'b0);
            do_swap("ring_swap");
        end

        // Reset in the middle of a load, then a full reload into core1.
        load_set("part_load", 30, 1'b0);
        rst_n = 0;
        model_reset();
        #1;
        check_all("rst_async");
        step("rst_hold");
        step("rst_hold");
        set_idle();
        rst_n = 1;
        step("rst_release");
        load_set("reload", ROWS, 1'b0);
        read_all("reload_rb", 2'd1);

        // Unconstrained mix of all inputs.
        for (int i = 0; i < 300; i++) begin
            rand_side();
            wl_valid = ($urandom_range(0, 1) == 1);
            wl_data  = rand_row();
            swap_req = ($urandom_range(0, 3) == 0);
            step("random");
        end
        set_idle();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
